// File: rtl/ld_vio_tracker.sv
// Load-violation tracker: holds the oldest pending violating load by active-list age,
// requests a flush when it reaches the AL head, then waits for the recovery.
module ld_vio_tracker #(
  parameter int unsigned AL_IDX_W = 7,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recoverFlag_i,
  input  logic                ldVioValid_i,
  input  logic [AL_IDX_W-1:0] ldVioAlID_i,
  input  logic [AL_IDX_W-1:0] alHead_i,
  output logic                vioPending_o,
  output logic [AL_IDX_W-1:0] vioAlID_o,
  output logic                flushReq_o,
  output logic                waitRecover_o,
  output logic [CNT_W-1:0]    vioCount_o
);

  typedef enum logic [1:0] {IDLE, PENDING, FLUSH, WAIT_RECOVER} state_t;

  state_t              state;
  logic [AL_IDX_W-1:0] rptAge;
  logic [AL_IDX_W-1:0] vioAge;
  logic                headMatch;
  logic                accept;

  // Ages relative to the AL head; modular subtraction handles index wrap-around.
  always_comb begin
    rptAge    = ldVioAlID_i - alHead_i;
    vioAge    = vioAlID_o - alHead_i;
    headMatch = (state == PENDING) && (vioAlID_o == alHead_i);
    accept    = ldVioValid_i && !recoverFlag_i && (state != WAIT_RECOVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      vioAlID_o     <= '0;
      vioPending_o  <= 1'b0;
      flushReq_o    <= 1'b0;
      waitRecover_o <= 1'b0;
      vioCount_o    <= '0;
    end else begin
      // Saturating perf counter; survives recovery, cleared only by reset.
      if (accept && (vioCount_o != {CNT_W{1'b1}})) begin
        vioCount_o <= vioCount_o + CNT_W'(1);
      end

      if (recoverFlag_i) begin
        state         <= IDLE;
        vioAlID_o     <= '0;
        vioPending_o  <= 1'b0;
        flushReq_o    <= 1'b0;
        waitRecover_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ldVioValid_i) begin
              state        <= PENDING;
              vioAlID_o    <= ldVioAlID_i;
              vioPending_o <= 1'b1;
            end
          end
          PENDING: begin
            if (headMatch) begin
              state        <= FLUSH;
              vioPending_o <= 1'b0;
              flushReq_o   <= 1'b1;
            end else if (ldVioValid_i && (rptAge < vioAge)) begin
              vioAlID_o <= ldVioAlID_i;
            end
          end
          FLUSH: begin
            state         <= WAIT_RECOVER;
            flushReq_o    <= 1'b0;
            waitRecover_o <= 1'b1;
          end
          WAIT_RECOVER: begin
            state <= WAIT_RECOVER;
          end
          default: begin
            state         <= IDLE;
            vioPending_o  <= 1'b0;
            flushReq_o    <= 1'b0;
            waitRecover_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ld_vio_tracker.sv
// Bench for ld_vio_tracker: directed scenarios plus random traffic against an age-ordered model.
module tb_ld_vio_tracker;
  localparam int unsigned AW  = 7;
  localparam int unsigned CW  = 16;
  localparam int unsigned SCW = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, recoverFlag_i, ldVioValid_i;
  logic [AW-1:0] ldVioAlID_i, alHead_i;
  logic          vioPending_o, flushReq_o, waitRecover_o;
  logic [AW-1:0] vioAlID_o;
  logic [CW-1:0] vioCount_o;
  logic          sPending, sFlush, sWait;
  logic [AW-1:0] sAlID;
  logic [SCW-1:0] sCount;

  ld_vio_tracker #(.AL_IDX_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
    .ldVioValid_i(ldVioValid_i), .ldVioAlID_i(ldVioAlID_i), .alHead_i(alHead_i),
    .vioPending_o(vioPending_o), .vioAlID_o(vioAlID_o), .flushReq_o(flushReq_o),
    .waitRecover_o(waitRecover_o), .vioCount_o(vioCount_o));

  // Narrow-counter instance on the same inputs so saturation is reached quickly.
  ld_vio_tracker #(.AL_IDX_W(AW), .CNT_W(SCW)) dutSat (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
    .ldVioValid_i(ldVioValid_i), .ldVioAlID_i(ldVioAlID_i), .alHead_i(alHead_i),
    .vioPending_o(sPending), .vioAlID_o(sAlID), .flushReq_o(sFlush),
    .waitRecover_o(sWait), .vioCount_o(sCount));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 holding, 2 flushing, 3 awaiting recovery.
  int mPhase = 0;
  int mId = 0;
  int mCnt = 0;
  int mCntS = 0;
  int hd = 0;

  function automatic int age(input int id, input int head);
    return (id - head + DEPTH) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("vioPending", 32'(vioPending_o), 32'(mPhase == 1));
    chk("flushReq", 32'(flushReq_o), 32'(mPhase == 2));
    chk("waitRecover", 32'(waitRecover_o), 32'(mPhase == 3));
    chk("vioAlID", 32'(vioAlID_o), 32'(mId));
    chk("vioCount", 32'(vioCount_o), 32'(mCnt));
    chk("satCount", 32'(sCount), 32'(mCntS));
    chk("satPending", 32'(sPending), 32'(mPhase == 1));
  endtask

  task automatic step(input bit v, input int id, input int head, input bit rec, input bit rst);
    reset         = rst;
    recoverFlag_i = rec;
    ldVioValid_i  = v;
    ldVioAlID_i   = AW'(id);
    alHead_i      = AW'(head);
    @(posedge clk);
    if (rst) begin
      mPhase = 0; mId = 0; mCnt = 0; mCntS = 0;
    end else if (rec) begin
      mPhase = 0; mId = 0;
    end else begin
      if (v && mPhase != 3) begin
        if (mCnt < (1 << CW) - 1) mCnt++;
        if (mCntS < (1 << SCW) - 1) mCntS++;
      end
      case (mPhase)
        0: if (v) begin mId = id; mPhase = 1; end
        1: if (mId == head) mPhase = 2;
           else if (v && age(id, head) < age(mId, head)) mId = id;
        2: mPhase = 3;
        default: mPhase = 3;
      endcase
    end
    #1;
    checkAll();
  endtask

  initial begin
    reset = 1'b1; recoverFlag_i = 1'b0; ldVioValid_i = 1'b0;
    ldVioAlID_i = '0; alHead_i = '0;
    #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

    // Older report replaces, younger one is only counted.
    step(1, 20, 10, 0, 0);
    step(1, 15, 10, 0, 0);
    chk("plan_id15", 32'(vioAlID_o), 32'd15);
    chk("plan_cnt2", 32'(vioCount_o), 32'd2);
    step(1, 30, 10, 0, 0);
    chk("plan_keep15", 32'(vioAlID_o), 32'd15);

    // Head reaches the held load: one-cycle flush, then wait; reports dropped.
    step(0, 0, 15, 0, 0);
    chk("plan_flush", 32'(flushReq_o), 32'd1);
    step(1, 40, 15, 0, 0);
    chk("plan_flushOnce", 32'(flushReq_o), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 17 + i, 15, 0, 0);
    step(0, 0, 15, 1, 0);
    chk("plan_cntKept", 32'(vioCount_o), 32'd4);

    // Wrap-around ordering across index 0.
    step(1, 5, 120, 0, 0);
    step(1, 125, 120, 0, 0);
    step(1, 2, 120, 0, 0);
    chk("plan_wrap125", 32'(vioAlID_o), 32'd125);

    // Recover beats a same-cycle report.
    step(1, 121, 120, 1, 0);
    step(0, 0, 120, 0, 0);

    // Report already at head: flush two cycles later; reset lands mid-flush.
    step(1, 50, 50, 0, 0);
    step(0, 0, 50, 0, 0);
    chk("plan_flush2", 32'(flushReq_o), 32'd1);
    step(0, 0, 50, 0, 1);
    step(0, 0, 50, 0, 0);

    // Random traffic; the narrow counter is driven well past saturation.
    hd = 0;
    for (int i = 0; i < 600; i++) begin
      bit v, rec, rst;
      int id;
      hd = (hd + int'($urandom_range(0, 1))) % DEPTH;
      if (mPhase == 1 && $urandom_range(0, 3) == 0) hd = mId;
      v   = ($urandom_range(0, 1) == 1);
      id  = (hd + int'($urandom_range(0, 60))) % DEPTH;
      rec = (mPhase == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 250) == 0);
      step(v, id, hd, rec, rst);
    end
    chk("satMax", 32'(mCntS), 32'((1 << SCW) - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
